// File: rtl/usb_tx_phy.sv
// Full-speed USB transmit PHY: SYNC generation, NRZI encoding, bit stuffing
// and EOP, driving D+/D- from a byte-wide SIE handshake.
module usb_tx_phy #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       d_p,
   output logic       d_n,
   output logic       d_oe
);

   localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SYNC    = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_EOP_SE0 = 3'd3;
   localparam logic [2:0] S_EOP_J   = 3'd4;

   logic [2:0]       state, state_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [2:0]       ones, ones_nxt;
   logic [7:0]       shifter, shifter_nxt;
   logic             last, last_nxt;          // line level of previous bit, 1 = J
   logic             byte_done, byte_done_nxt; // 8th bit sent, stuff bit still owed
   logic             tx_ready_nxt, d_p_nxt, d_n_nxt, d_oe_nxt;

   logic strobe, stuff, cur_bit, level, boundary;

   // Bit timing, current bit value and its NRZI line level
   always_comb begin
      strobe  = (div == DIV_LAST);
      stuff   = (state == S_DATA) && (ones == 3'd6);
      if (state == S_SYNC)
         cur_bit = (bit_cnt == 3'd7);
      else if (stuff)
         cur_bit = 1'b0;
      else
         cur_bit = shifter[bit_cnt];
      level = cur_bit ? last : ~last;
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      div_nxt       = strobe ? '0 : div + DIV_W'(1);
      bit_cnt_nxt   = bit_cnt;
      ones_nxt      = ones;
      shifter_nxt   = shifter;
      last_nxt      = last;
      byte_done_nxt = byte_done;
      tx_ready_nxt  = 1'b0;
      d_p_nxt       = 1'b1;
      d_n_nxt       = 1'b0;
      d_oe_nxt      = 1'b0;
      boundary      = 1'b0;

      case (state)
         S_IDLE: begin
            div_nxt = '0;
            if (tx_valid) begin
               state_nxt     = S_SYNC;
               bit_cnt_nxt   = 3'd0;
               ones_nxt      = 3'd0;
               last_nxt      = 1'b1;
               byte_done_nxt = 1'b0;
            end
         end
         S_SYNC: begin
            d_p_nxt  = level;
            d_n_nxt  = ~level;
            d_oe_nxt = 1'b1;
            if (strobe) begin
               last_nxt = level;
               if (bit_cnt == 3'd7) begin
                  ones_nxt = 3'd1;
                  boundary = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         S_DATA: begin
            d_p_nxt  = level;
            d_n_nxt  = ~level;
            d_oe_nxt = 1'b1;
            if (strobe) begin
               last_nxt = level;
               if (stuff) begin
                  ones_nxt = 3'd0;
                  if (byte_done) begin
                     byte_done_nxt = 1'b0;
                     boundary      = 1'b1;
                  end
               end else begin
                  ones_nxt = cur_bit ? ones + 3'd1 : 3'd0;
                  if (bit_cnt == 3'd7) begin
                     if (cur_bit && (ones == 3'd5))
                        byte_done_nxt = 1'b1;
                     else
                        boundary = 1'b1;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 3'd1;
                  end
               end
            end
         end
         S_EOP_SE0: begin
            d_p_nxt  = 1'b0;
            d_n_nxt  = 1'b0;
            d_oe_nxt = 1'b1;
            if (strobe) begin
               if (bit_cnt == 3'd1) begin
                  state_nxt   = S_EOP_J;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         S_EOP_J: begin
            d_oe_nxt = 1'b1;
            if (strobe) begin
               state_nxt = S_IDLE;
               ones_nxt  = 3'd0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Byte boundary: take the next byte or close the packet
      if (boundary) begin
         bit_cnt_nxt = 3'd0;
         if (tx_valid) begin
            state_nxt    = S_DATA;
            shifter_nxt  = tx_data;
            tx_ready_nxt = 1'b1;
         end else begin
            state_nxt = S_EOP_SE0;
         end
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         div       <= '0;
         bit_cnt   <= 3'd0;
         ones      <= 3'd0;
         shifter   <= 8'd0;
         last      <= 1'b1;
         byte_done <= 1'b0;
         tx_ready  <= 1'b0;
         d_p       <= 1'b1;
         d_n       <= 1'b0;
         d_oe      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div       <= div_nxt;
         bit_cnt   <= bit_cnt_nxt;
         ones      <= ones_nxt;
         shifter   <= shifter_nxt;
         last      <= last_nxt;
         byte_done <= byte_done_nxt;
         tx_ready  <= tx_ready_nxt;
         d_p       <= d_p_nxt;
         d_n       <= d_n_nxt;
         d_oe      <= d_oe_nxt;
      end
   end

endmodule

// File: tb/tb_usb_tx_phy.sv
// Testbench for usb_tx_phy: a reference line-symbol stream is queued per
// packet and compared clock by clock against D+/D- while d_oe is high.
module tb_usb_tx_phy;

   localparam int unsigned CPB = 4;
   localparam logic [1:0] SYM_J   = 2'b10;
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, d_p, d_n, d_oe;

   usb_tx_phy #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .d_p      (d_p),
      .d_n      (d_n),
      .d_oe     (d_oe)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   logic [1:0] exp_q[$];
   logic [7:0] pkt[8];
   int         m_ones;
   logic       m_level;
   int         oe_cnt, rdy_cnt, cyc;
   int         rdy_at[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference encoder: one queue entry per clock
   task automatic push_sym(input logic [1:0] s);
      repeat (CPB) exp_q.push_back(s);
   endtask

   task automatic send_bit(input logic b);
      if (!b) m_level = ~m_level;
      push_sym(m_level ? SYM_J : SYM_K);
      m_ones = b ? m_ones + 1 : 0;
      if (m_ones == 6) begin
         m_level = ~m_level;
         push_sym(m_level ? SYM_J : SYM_K);
         m_ones = 0;
      end
   endtask

   task automatic build(input int n);
      logic [7:0] b;
      m_level = 1'b1;
      m_ones  = 0;
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < n; i++) begin
         b = pkt[i];
         for (int j = 0; j < 8; j++) send_bit(b[j]);
      end
      push_sym(SYM_SE0);
      push_sym(SYM_SE0);
      push_sym(SYM_J);
   endtask

   // One clock: sample on the falling edge and compare the line
   task automatic tick();
      logic [1:0] e;
      @(negedge clk);
      cyc++;
      if (d_oe) begin
         oe_cnt++;
         if (exp_q.size() == 0) begin
            check("line_extra", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("line", 32'({d_p, d_n}), 32'(e));
         end
      end
      if (tx_ready) begin
         rdy_cnt++;
         rdy_at.push_back(cyc);
      end
   endtask

   task automatic run_pkt(input int n, input bit pulse, input int exp_oe, input string tag);
      int idx;
      bit started, done;
      build(n);
      oe_cnt = 0;
      rdy_cnt = 0;
      rdy_at.delete();
      idx = 0;
      started = 0;
      done = 0;
      tx_data = pkt[0];
      tx_valid = 1'b1;
      for (int c = 0; c < 4000 && !done; c++) begin
         tick();
         if (tx_ready) begin
            idx++;
            if (idx < n) tx_data = pkt[idx];
            else tx_valid = 1'b0;
         end else if (c == 0 && n == 0) begin
            tx_valid = 1'b0;
         end else if (pulse && rdy_cnt == 0) begin
            tx_valid = (c >= 24) || (c % 2 == 1);
         end
         if (d_oe) started = 1;
         else if (started) done = 1;
      end
      tx_valid = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_oe_clks"}, 32'(oe_cnt), 32'(exp_oe));
      check({tag, "_ready_cnt"}, 32'(rdy_cnt), 32'(n));
      check({tag, "_sym_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int guard;
      cyc = 0;
      oe_cnt = 0;
      rdy_cnt = 0;
      reset = 1'b1;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      #1;
      check("rst_d_p", 32'(d_p), 32'd1);
      check("rst_d_n", 32'(d_n), 32'd0);
      check("rst_d_oe", 32'(d_oe), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // ACK
      pkt[0] = 8'hD2;
      run_pkt(1, 1'b0, 76, "ack");

      // Two 0xFF bytes: stuffing after data bits 5 and 11
      pkt[0] = 8'hFF; pkt[1] = 8'hFF;
      run_pkt(2, 1'b0, 116, "ff_ff");

      // Trailing six ones: stuff before EOP
      pkt[0] = 8'hFC;
      run_pkt(1, 1'b0, 80, "fc");

      // Streamed zeros: ready spacing one byte time
      pkt[0] = 8'h00; pkt[1] = 8'h00; pkt[2] = 8'h00;
      run_pkt(3, 1'b0, 140, "zeros");
      if (rdy_at.size() >= 3) begin
         check("zeros_gap1", 32'(rdy_at[1] - rdy_at[0]), 32'(8 * CPB));
         check("zeros_gap2", 32'(rdy_at[2] - rdy_at[1]), 32'(8 * CPB));
      end

      // No-data packet: SYNC then EOP
      run_pkt(0, 1'b0, 44, "nodata");

      // tx_valid toggling during SYNC is ignored
      pkt[0] = 8'h5A;
      run_pkt(1, 1'b1, 76, "pulse");

      // Reset in the middle of byte 1
      repeat (2) tick();
      pkt[0] = 8'hA5; pkt[1] = 8'h3C;
      build(2);
      rdy_cnt = 0;
      tx_data = pkt[0];
      tx_valid = 1'b1;
      guard = 0;
      while (rdy_cnt == 0 && guard < 200) begin
         tick();
         guard++;
      end
      check("rst_mid_ready_seen", 32'(rdy_cnt), 32'd1);
      tx_data = pkt[1];
      repeat (3 * CPB + 1) tick();
      #2 reset = 1'b1;
      #1;
      check("rst_mid_d_oe", 32'(d_oe), 32'd0);
      check("rst_mid_d_p", 32'(d_p), 32'd1);
      check("rst_mid_d_n", 32'(d_n), 32'd0);
      check("rst_mid_ready", 32'(tx_ready), 32'd0);
      exp_q.delete();
      tx_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      oe_cnt = 0;
      repeat (20) tick();
      check("post_rst_idle_oe", 32'(oe_cnt), 32'd0);
      check("post_rst_idle_j", 32'({d_p, d_n}), 32'(SYM_J));

      // Clean packet after reset
      pkt[0] = 8'hD2;
      run_pkt(1, 1'b0, 76, "after_rst");

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
